// File: rtl/md5_gen_pkg.sv
// Shared constants and helpers for the MD5 candidate generator.
// Single-block MD5 padding: message bytes, 0x80 pad byte, 64-bit bit-length field.
package md5_gen_pkg;

   localparam int unsigned CHUNK_W       = 512;
   localparam int unsigned CHAR_W        = 8;
   localparam int unsigned WORD_W        = 32;
   localparam int unsigned LEN_WORD_IDX  = 14;
   localparam int unsigned MAX_MSG_BYTES = 55;
   localparam logic [CHAR_W-1:0] MD5_PAD_BYTE = 8'h80;

   // Low word of the MD5 length field: message length in bits.
   function automatic logic [WORD_W-1:0] bit_len_field(input int unsigned len_bytes);
      return WORD_W'(len_bytes * 8);
   endfunction

endpackage

// File: rtl/md5_chunk_pack.sv
// Combinational packer: candidate digits plus length into one padded MD5 block.
// Bytes past the pad byte are always driven to zero, so nothing stale leaks through.
module md5_chunk_pack
   import md5_gen_pkg::*;
#(
   parameter int unsigned MAX_LEN = 8,
   parameter int unsigned LEN_W   = 6
) (
   input  logic [MAX_LEN*CHAR_W-1:0] i_digits,
   input  logic [LEN_W-1:0]          i_len,
   output logic [CHUNK_W-1:0]        o_chunk_c
);

   always_comb begin
      o_chunk_c = '0;
      for (int j = 0; j < MAX_LEN; j++) begin
         if (LEN_W'(j) < i_len)
            o_chunk_c[j*CHAR_W +: CHAR_W] = i_digits[j*CHAR_W +: CHAR_W];
      end
      // Pad byte position equals the length, which never exceeds MAX_LEN.
      for (int j = 1; j <= MAX_LEN; j++) begin
         if (LEN_W'(j) == i_len)
            o_chunk_c[j*CHAR_W +: CHAR_W] = MD5_PAD_BYTE;
      end
      o_chunk_c[LEN_WORD_IDX*WORD_W +: WORD_W] = bit_len_field(32'(i_len));
   end

endmodule

// File: rtl/md5_candidate_chunk_gen.sv
// Enumerates every string over [min..max], shortest first, emitting one padded
// MD5 block per enabled cycle together with its length and ordinal.
module md5_candidate_chunk_gen
   import md5_gen_pkg::*;
#(
   parameter int unsigned MAX_LEN = 8,
   parameter int unsigned LEN_W   = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [CHAR_W-1:0]  min,
   input  logic [CHAR_W-1:0]  max,
   input  logic [LEN_W-1:0]   start_len,
   input  logic               en,
   output logic [CHUNK_W-1:0] chunk,
   output logic               chunk_valid,
   output logic [LEN_W-1:0]   len,
   output logic [63:0]        index,
   output logic               exhausted
);

   localparam int unsigned DIG_W = MAX_LEN * CHAR_W;

   logic [CHAR_W-1:0]  r_min;
   logic [CHAR_W-1:0]  r_max;
   logic [LEN_W-1:0]   r_len;
   logic [DIG_W-1:0]   r_digits;
   logic [63:0]        r_cnt;
   logic [CHUNK_W-1:0] r_chunk;
   logic               r_valid;
   logic [LEN_W-1:0]   r_olen;
   logic [63:0]        r_index;
   logic               r_exh;

   logic [LEN_W-1:0]   w_start_len;
   logic [DIG_W-1:0]   w_next_digits;
   logic               w_carry;
   logic [CHUNK_W-1:0] w_chunk;
   logic               w_emit;

   md5_chunk_pack #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_pack (
      .i_digits  (r_digits),
      .i_len     (r_len),
      .o_chunk_c (w_chunk)
   );

   always_comb begin
      w_start_len = start_len;
      if (start_len == '0)
         w_start_len = LEN_W'(1);
      else if (start_len > LEN_W'(MAX_LEN))
         w_start_len = LEN_W'(MAX_LEN);
   end

   // Odometer increment over the active digits; w_carry set means the length rolled over.
   always_comb begin
      w_next_digits = r_digits;
      w_carry       = 1'b1;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (w_carry && (LEN_W'(i) < r_len)) begin
            if (r_digits[i*CHAR_W +: CHAR_W] == r_max) begin
               w_next_digits[i*CHAR_W +: CHAR_W] = r_min;
            end else begin
               w_next_digits[i*CHAR_W +: CHAR_W] = r_digits[i*CHAR_W +: CHAR_W] + 8'd1;
               w_carry = 1'b0;
            end
         end
      end
   end

   assign w_emit = en && !r_exh && (r_min <= r_max);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_min    <= min;
         r_max    <= max;
         r_len    <= w_start_len;
         r_digits <= {MAX_LEN{min}};
         r_cnt    <= '0;
         r_chunk  <= '0;
         r_valid  <= 1'b0;
         r_olen   <= '0;
         r_index  <= '0;
         r_exh    <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (r_min > r_max) begin
            r_exh <= 1'b1;
         end else if (w_emit) begin
            r_chunk <= w_chunk;
            r_valid <= 1'b1;
            r_olen  <= r_len;
            r_index <= r_cnt;
            r_cnt   <= r_cnt + 64'd1;
            if (!w_carry) begin
               r_digits <= w_next_digits;
            end else if (r_len < LEN_W'(MAX_LEN)) begin
               r_len    <= r_len + LEN_W'(1);
               r_digits <= {MAX_LEN{r_min}};
            end else begin
               r_exh <= 1'b1;
            end
         end
      end
   end

   assign chunk       = r_chunk;
   assign chunk_valid = r_valid;
   assign len         = r_olen;
   assign index       = r_index;
   assign exhausted   = r_exh;

endmodule

// File: tb/tb_md5_candidate_chunk_gen.sv
// Directed plus randomized bench for md5_candidate_chunk_gen against an ordinal-based
// reference model; runs a MAX_LEN=2 and a MAX_LEN=8 instance side by side.
module tb_md5_candidate_chunk_gen;

   logic         clk = 1'b0;
   logic         reset, en;
   logic [7:0]   mn, mx;
   logic [5:0]   sl;

   logic [511:0] c2, c8;
   logic         v2, v8, x2, x8;
   logic [5:0]   l2, l8;
   logic [63:0]  i2, i8;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   md5_candidate_chunk_gen #(.MAX_LEN(2), .LEN_W(6)) dut2 (
      .clk(clk), .reset(reset), .min(mn), .max(mx), .start_len(sl), .en(en),
      .chunk(c2), .chunk_valid(v2), .len(l2), .index(i2), .exhausted(x2));

   md5_candidate_chunk_gen #(.MAX_LEN(8), .LEN_W(6)) dut8 (
      .clk(clk), .reset(reset), .min(mn), .max(mx), .start_len(sl), .en(en),
      .chunk(c8), .chunk_valid(v8), .len(l8), .index(i8), .exhausted(x8));

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int clampl(input int st, input int ml);
      if (st < 1) return 1;
      if (st > ml) return ml;
      return st;
   endfunction

   function automatic longint pw(input longint b, input int e);
      longint p = 1;
      for (int k = 0; k < e; k++) p = p * b;
      return p;
   endfunction

   function automatic longint total(input int lo, input int hi, input int st, input int ml);
      longint t = 0;
      for (int l = clampl(st, ml); l <= ml; l++) t += pw(hi - lo + 1, l);
      return t;
   endfunction

   // Candidate number n: skip whole length groups, then write n in base (hi-lo+1), LSB first.
   function automatic logic [511:0] model(input int lo, input int hi, input int st, input int ml,
                                          input longint n, output int l);
      logic [511:0] ch = '0;
      longint b = hi - lo + 1;
      longint rem = n;
      l = clampl(st, ml);
      while (l < ml && rem >= pw(b, l)) begin
         rem -= pw(b, l);
         l++;
      end
      for (int j = 0; j < l; j++) begin
         ch[8*j +: 8] = 8'(lo + int'(rem % b));
         rem = rem / b;
      end
      ch[8*l +: 8]   = 8'h80;
      ch[479:448]    = 32'(l * 8);
      return ch;
   endfunction

   task automatic do_reset(input int lo, input int hi, input int st);
      reset = 1'b1;
      mn = 8'(lo); mx = 8'(hi); sl = 6'(st);
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic [511:0] exp, last2, last8;
      int           l, n, n2, n8, lo, hi, st;
      int           enp [5];
      longint       t2, t8;

      reset = 1'b1; en = 1'b0; mn = 8'h61; mx = 8'h63; sl = 6'd1;

      // Reset state
      tick(); tick();
      chk("rst_chunk", c2, 0);
      chk("rst_valid", v2, 0);
      chk("rst_len", l2, 0);
      chk("rst_index", i2, 0);
      chk("rst_exh", x2, 0);

      // Full small keyspace a..c, lengths 1..2
      reset = 1'b0; en = 1'b1;
      n = 0;
      for (int k = 0; k < 16; k++) begin
         tick();
         if (v2) begin
            exp = model(8'h61, 8'h63, 1, 2, n, l);
            chk("full_chunk", c2, exp);
            chk("full_len", l2, l);
            chk("full_index", i2, n);
            if (n == 0) begin
               chk("pad_a_byte0", c2[7:0], 8'h61);
               chk("pad_a_byte1", c2[15:8], 8'h80);
               chk("pad_a_word14", c2[479:448], 32'h8);
            end
            if (n == 3) begin
               chk("pad_aa_byte2", c2[23:16], 8'h80);
               chk("pad_aa_word14", c2[479:448], 32'h10);
            end
            n++;
            if (n < 12) chk("full_exh_early", x2, 0);
         end else begin
            chk("full_valid_after_end", n, 12);
            chk("full_exh_after_end", x2, 1);
         end
      end
      chk("full_count", n, 12);

      // Stall behaviour over digits 0..9
      en = 1'b0;
      do_reset(8'h30, 8'h39, 1);
      chk("stall_rst_valid", v2, 0);
      enp = '{1, 0, 0, 1, 0};
      n = 0;
      for (int k = 0; k < 5; k++) begin
         en = enp[k][0];
         tick();
         chk("stall_valid", v2, enp[k]);
         if (enp[k] != 0) n++;
         exp = model(8'h30, 8'h39, 1, 2, n - 1, l);
         chk("stall_chunk", c2, exp);
         chk("stall_index", i2, n - 1);
      end

      // start_len = 0 acts as 1
      en = 1'b1;
      do_reset(8'h61, 8'h63, 0);
      tick();
      chk("sl0_len", l2, 1);
      chk("sl0_chunk", c2, model(8'h61, 8'h63, 0, 2, 0, l));

      // start_len = 9 clamps to MAX_LEN
      do_reset(8'h61, 8'h7a, 9);
      tick();
      exp = '0;
      for (int j = 0; j < 8; j++) exp[8*j +: 8] = 8'h61;
      exp[71:64]   = 8'h80;
      exp[479:448] = 32'h40;
      chk("sl9_len8", l8, 8);
      chk("sl9_chunk8", c8, exp);
      chk("sl9_len2", l2, 2);
      for (int k = 1; k < 4; k++) begin
         tick();
         chk("sl9_next8", c8, model(8'h61, 8'h7a, 9, 8, k, l));
      end

      // Inverted range
      do_reset(8'h7a, 8'h61, 1);
      tick();
      chk("inv_exh2", x2, 1);
      chk("inv_exh8", x8, 1);
      for (int k = 0; k < 3; k++) begin
         chk("inv_valid", v2, 0);
         tick();
      end

      // Reset mid-run with new min; later min/max changes ignored
      do_reset(8'h61, 8'h63, 1);
      for (int k = 0; k < 5; k++) tick();
      chk("mid_pre_valid", v2, 1);
      reset = 1'b1; mn = 8'h41; mx = 8'h43;
      tick();
      chk("mid_rst_valid", v2, 0);
      chk("mid_rst_index", i2, 0);
      reset = 1'b0; mn = 8'h50; mx = 8'h55;
      tick();
      chk("mid_chunk", c2, model(8'h41, 8'h43, 1, 2, 0, l));
      chk("mid_index", i2, 0);
      tick();
      chk("mid_chunk2", c2, model(8'h41, 8'h43, 1, 2, 1, l));

      // Randomized configurations and enable patterns
      for (int t = 0; t < 8; t++) begin
         lo = int'($urandom_range(32, 120));
         hi = lo + int'($urandom_range(0, 3));
         st = int'($urandom_range(0, 3));
         en = 1'b0;
         do_reset(lo, hi, st);
         t2 = total(lo, hi, st, 2);
         t8 = total(lo, hi, st, 8);
         n2 = 0; n8 = 0; last2 = '0; last8 = '0;
         for (int k = 0; k < 200; k++) begin
            en = 1'($urandom_range(0, 1));
            tick();
            if (v2) begin
               last2 = model(lo, hi, st, 2, n2, l);
               chk("rnd2_len", l2, l);
               chk("rnd2_index", i2, n2);
               n2++;
            end
            chk("rnd2_chunk", c2, last2);
            chk("rnd2_exh", x2, (n2 >= t2) ? 1 : 0);
            if (v8) begin
               last8 = model(lo, hi, st, 8, n8, l);
               chk("rnd8_len", l8, l);
               chk("rnd8_index", i8, n8);
               n8++;
            end
            chk("rnd8_chunk", c8, last8);
            chk("rnd8_exh", x8, (n8 >= t8) ? 1 : 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
